dm_cache_ctrl: RTL and testbench

Direct-mapped, write-back, write-allocate cache controller between the CPU and a 1M x 16 secondary memory. It owns the tag store and the data store (1024 lines x 64 bits) and accepts one CPU read or write at a time. It serves hits from the data store, and sequences write-back and line refill over a single-outstanding-request memory port. Port groups map field-for-field onto `cpu_to_cache_type`, `cache_to_cpu_type`, `cache_to_mem_type` and `mem_to_cache_type` in `cache_definition`.

---
 rtl/dm_cache_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_dm_cache_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dm_cache_ctrl.sv
// rtl/dm_cache_ctrl.sv - direct-mapped write-back write-allocate cache controller
module dm_cache_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [19:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    input  logic        cpu_rw,
    input  logic        cpu_valid,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ready,
    output logic [19:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        mem_rw,
    output logic        mem_valid,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        COMPARE    = 2'd1,
        WRITE_BACK = 2'd2,
        ALLOCATE   = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Line storage; only the valid/dirty bits need a known value after reset.
    logic [63:0]   data_store [0:1023];
    logic [7:0]    tag_store  [0:1023];
    logic [1023:0] valid_bits;
    logic [1023:0] dirty_bits;

    // Captured CPU request, used for the whole transaction.
    logic [19:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_rw;

    logic [7:0]  req_tag;
    logic [9:0]  req_index;
    logic [1:0]  req_word;
    logic [5:0]  word_lsb;

    logic [63:0] cur_line;
    logic [7:0]  cur_tag;
    logic        cur_valid;
    logic        cur_dirty;
    logic        hit;
    logic [15:0] sel_word;
    logic [63:0] merged_line;

    // Strobes decoded by the FSM and consumed by the storage/output registers.
    logic        accept;
    logic        rd_hit;
    logic        wr_hit;
    logic        refill;

    assign req_tag   = req_addr[19:12];
    assign req_index = req_addr[11:2];
    assign req_word  = req_addr[1:0];
    assign word_lsb  = {req_word, 4'b0000};

    assign cur_line  = data_store[req_index];
    assign cur_tag   = tag_store[req_index];
    assign cur_valid = valid_bits[req_index];
    assign cur_dirty = dirty_bits[req_index];
    assign hit       = cur_valid && (cur_tag == req_tag);
    assign sel_word  = cur_line[word_lsb +: 16];

    // Line image with the requested word replaced by the write data.
    always_comb begin
        merged_line                  = cur_line;
        merged_line[word_lsb +: 16]  = req_wdata;
    end

    // State register; reset abandons any request in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, memory port decode and internal strobes.
    always_comb begin
        state_next = state;
        mem_valid  = 1'b0;
        mem_rw     = 1'b0;
        mem_addr   = 20'h0_0000;
        mem_wdata  = 64'h0;
        accept     = 1'b0;
        rd_hit     = 1'b0;
        wr_hit     = 1'b0;
        refill     = 1'b0;
        case (state)
            IDLE: begin
                // The cycle showing cpu_ready still sees the old cpu_valid.
                if (cpu_valid && !cpu_ready) begin
                    accept     = 1'b1;
                    state_next = COMPARE;
                end
            end
            COMPARE: begin
                if (hit) begin
                    rd_hit     = !req_rw;
                    wr_hit     = req_rw;
                    state_next = IDLE;
                end else if (cur_valid && cur_dirty) begin
                    state_next = WRITE_BACK;
                end else begin
                    state_next = ALLOCATE;
                end
            end
            WRITE_BACK: begin
                mem_valid = 1'b1;
                mem_rw    = 1'b1;
                mem_addr  = {cur_tag, req_index, 2'b00};
                mem_wdata = cur_line;
                if (mem_ready) begin
                    state_next = ALLOCATE;
                end
            end
            ALLOCATE: begin
                mem_valid = 1'b1;
                mem_addr  = {req_tag, req_index, 2'b00};
                if (mem_ready) begin
                    refill     = 1'b1;
                    state_next = COMPARE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request capture on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_addr  <= 20'h0_0000;
            req_wdata <= 16'h0000;
            req_rw    <= 1'b0;
        end else if (accept) begin
            req_addr  <= cpu_addr;
            req_wdata <= cpu_wdata;
            req_rw    <= cpu_rw;
        end
    end

    // Data and tag stores: refill from memory or merge a write hit.
    always_ff @(posedge clk) begin
        if (refill) begin
            data_store[req_index] <= mem_rdata;
            tag_store[req_index]  <= req_tag;
        end else if (wr_hit) begin
            data_store[req_index] <= merged_line;
        end
    end

    // Valid/dirty bookkeeping; a refilled line starts clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_bits <= '0;
            dirty_bits <= '0;
        end else if (refill) begin
            valid_bits[req_index] <= 1'b1;
            dirty_bits[req_index] <= 1'b0;
        end else if (wr_hit) begin
            dirty_bits[req_index] <= 1'b1;
        end
    end

    // CPU response: one-cycle ready pulse, read data held between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_ready <= 1'b0;
            cpu_rdata <= 16'h0000;
        end else begin
            cpu_ready <= rd_hit || wr_hit;
            if (rd_hit) begin
                cpu_rdata <= sel_word;
            end
        end
    end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb/tb_dm_cache_ctrl.sv - directed self-checking bench for dm_cache_ctrl
module tb_dm_cache_ctrl;

    logic        clk;
    logic        rst_n;
    logic [19:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_rw;
    logic        cpu_valid;
    logic [15:0] cpu_rdata;
    logic        cpu_ready;
    logic [19:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_rw;
    logic        mem_valid;
    logic [63:0] mem_rdata;
    logic        mem_ready;

    int checks = 0;
    int errors = 0;

    // Per-transaction observations gathered by do_req.
    int          n_wb;
    int          n_al;
    int          n_cycles;
    logic [19:0] wb_addr;
    logic [63:0] wb_data;
    logic [19:0] al_addr;
    logic        stall_bad;

    dm_cache_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rw    (cpu_rw),
        .cpu_valid (cpu_valid),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rw    (mem_rw),
        .mem_valid (mem_valid),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One CPU transaction with an inline memory responder; stall applies to refills.
    task automatic do_req(input logic [19:0] a, input logic [15:0] d, input logic rw,
                          input logic [63:0] line, input int stall);
        int waitc;
        waitc     = 0;
        n_wb      = 0;
        n_al      = 0;
        n_cycles  = 0;
        stall_bad = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        al_addr   = '0;
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_rw    = rw;
        cpu_valid = 1'b1;
        mem_rdata = line;
        while (!cpu_ready && n_cycles < 200) begin
            @(negedge clk);
            n_cycles++;
            mem_ready = 1'b0;
            if (mem_valid && !cpu_ready) begin
                if (!mem_rw && waitc < stall) begin
                    waitc++;
                    if (mem_addr !== a || cpu_ready !== 1'b0) stall_bad = 1'b1;
                    cpu_valid = ~cpu_valid;
                end else begin
                    cpu_valid = 1'b1;
                    mem_ready = 1'b1;
                    waitc     = 0;
                    if (mem_rw) begin
                        n_wb++;
                        wb_addr = mem_addr;
                        wb_data = mem_wdata;
                    end else begin
                        n_al++;
                        al_addr = mem_addr;
                    end
                end
            end
        end
        cpu_valid = 1'b0;
        mem_ready = 1'b0;
        chk("ready_seen", {63'd0, cpu_ready}, 64'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_rw    = 1'b0;
        cpu_valid = 1'b0;
        mem_rdata = '0;
        mem_ready = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_cpu_ready", {63'd0, cpu_ready}, 64'd0);
        chk("rst_cpu_rdata", {48'd0, cpu_rdata}, 64'd0);
        chk("rst_mem_valid", {63'd0, mem_valid}, 64'd0);
        chk("rst_mem_rw",    {63'd0, mem_rw},    64'd0);
        chk("rst_mem_addr",  {44'd0, mem_addr},  64'd0);
        chk("rst_mem_wdata", mem_wdata,          64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Cold read miss.
        do_req(20'h01234, 16'h0000, 1'b0, 64'h4444_3333_2222_1111, 0);
        chk("cold_n_wb",   n_wb,     0);
        chk("cold_n_al",   n_al,     1);
        chk("cold_al_addr", {44'd0, al_addr}, 64'h01234);
        chk("cold_rdata",  {48'd0, cpu_rdata}, 64'h1111);
        chk("cold_cycles", n_cycles, 4);
        @(negedge clk);
        chk("cold_pulse_width", {63'd0, cpu_ready}, 64'd0);

        // Read hit, word 3.
        do_req(20'h01237, 16'h0000, 1'b0, 64'h0, 0);
        chk("hit_mem_traffic", n_wb + n_al, 0);
        chk("hit_rdata",  {48'd0, cpu_rdata}, 64'h4444);
        chk("hit_cycles", n_cycles, 2);
        @(negedge clk);

        // Write hit, word 1; read data must hold.
        do_req(20'h01235, 16'hBEEF, 1'b1, 64'h0, 0);
        chk("whit_mem_traffic", n_wb + n_al, 0);
        chk("whit_cycles", n_cycles, 2);
        chk("whit_rdata_hold", {48'd0, cpu_rdata}, 64'h4444);
        @(negedge clk);

        // Dirty eviction by a read of tag 0x02 at the same index.
        do_req(20'h02234, 16'h0000, 1'b0, 64'h8888_7777_6666_5555, 0);
        chk("evict_n_wb",    n_wb, 1);
        chk("evict_wb_addr", {44'd0, wb_addr}, 64'h01234);
        chk("evict_wb_data", wb_data, 64'h4444_3333_BEEF_1111);
        chk("evict_n_al",    n_al, 1);
        chk("evict_al_addr", {44'd0, al_addr}, 64'h02234);
        chk("evict_rdata",   {48'd0, cpu_rdata}, 64'h5555);
        chk("evict_cycles",  n_cycles, 5);
        @(negedge clk);

        // Write miss on a clean line: allocate only.
        do_req(20'h03234, 16'h00AA, 1'b1, 64'hDDDD_CCCC_BBBB_AAAA, 0);
        chk("wmiss_n_wb",    n_wb, 0);
        chk("wmiss_n_al",    n_al, 1);
        chk("wmiss_al_addr", {44'd0, al_addr}, 64'h03234);
        chk("wmiss_rdata_hold", {48'd0, cpu_rdata}, 64'h5555);
        @(negedge clk);

        // Eviction of the merged line, with a 20-cycle refill stall.
        do_req(20'h04234, 16'h0000, 1'b0, 64'h0123_4567_89AB_CDEF, 20);
        chk("stall_n_wb",    n_wb, 1);
        chk("stall_wb_addr", {44'd0, wb_addr}, 64'h03234);
        chk("stall_wb_data", wb_data, 64'hDDDD_CCCC_BBBB_00AA);
        chk("stall_n_al",    n_al, 1);
        chk("stall_stable",  {63'd0, stall_bad}, 64'd0);
        chk("stall_rdata",   {48'd0, cpu_rdata}, 64'hCDEF);
        chk("stall_cycles",  n_cycles, 25);
        @(negedge clk);

        // Reset in the middle of ALLOCATE.
        cpu_addr  = 20'h05234;
        cpu_rw    = 1'b0;
        cpu_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_alloc_valid", {63'd0, mem_valid}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_drop_valid", {63'd0, mem_valid}, 64'd0);
        chk("async_no_ready",   {63'd0, cpu_ready}, 64'd0);
        cpu_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Every line is invalid again.
        do_req(20'h01234, 16'h0000, 1'b0, 64'h1357_2468_9ABC_DEF0, 0);
        chk("post_rst_n_wb", n_wb, 0);
        chk("post_rst_n_al", n_al, 1);
        chk("post_rst_rdata", {48'd0, cpu_rdata}, 64'hDEF0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
